shift_reg_param: RTL and testbench
==================================

# shift_reg_param

Parametrised multi-mode word shift register: the generalised successor of the team's fixed 4-stage, 1-bit delay line. It stores DEPTH words of WIDTH bits and supports clock-enabled serial shift, rotate, parallel load and clear. Each stage carries a valid flag, and the block keeps an occupancy count. A registered, run-time selectable tap output is provided. It sits between input capture logic and downstream consumers as a configurable delay, alignment or sample-window buffer.

## Interface
- WIDTH, 8: data word width in bits (>=1)
- DEPTH, 16: number of stages (>=2); AW = $clog2(DEPTH), CW = $clog2(DEPTH+1)
- sys_clk  in  1  system clock, all state on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- en  in  1  clock enable; 0 = hold all stage, valid and count state
- mode  in  2  00 shift, 01 rotate, 10 parallel load, 11 clear (sampled only when en=1)
- din  in  WIDTH  serial input word
- din_vld  in  1  valid flag for din
- load_data  in  DEPTH*WIDTH  parallel load image; slice i = bits [i*WIDTH +: WIDTH] -> stage i
- tap_sel  in  AW  tap stage index
- dout  out  WIDTH  stage DEPTH-1 contents, direct from register
- dout_vld  out  1  valid flag of stage DEPTH-1
- tap_out  out  WIDTH  registered copy of the stage selected by tap_sel
- tap_vld  out  1  registered valid flag of the selected stage
- fill_cnt  out  CW  number of stages with valid flag set (0..DEPTH)
- full  out  1  fill_cnt == DEPTH

## Operation
- State: data s[0..DEPTH-1] and valid flags v[0..DEPTH-1]. s[0] is the newest stage.
- en=0: s, v and fill_cnt hold regardless of mode. The tap register still updates.
- Shift (00): s[0]<=din, v[0]<=din_vld; s[i]<=s[i-1], v[i]<=v[i-1].
  - fill_cnt <= fill_cnt + din_vld - v[DEPTH-1].
  - Data leaving stage DEPTH-1 is discarded.
- Rotate (01): s[0]<=s[DEPTH-1], v[0]<=v[DEPTH-1]; s[i]<=s[i-1], v[i]<=v[i-1]. fill_cnt unchanged. din and din_vld are ignored.
- Parallel load (10): s[i]<=load_data slice i; all v<=1; fill_cnt<=DEPTH.
- Clear (11): all s<=0, all v<=0, fill_cnt<=0.
- Tap register, every cycle:
  - tap_sel < DEPTH: tap_out<=s[tap_sel], tap_vld<=v[tap_sel] (pre-update stage contents).
  - tap_sel >= DEPTH (possible when DEPTH is not a power of 2): tap_out<=0, tap_vld<=0.
- fill_cnt never exceeds DEPTH and never underflows. This is guaranteed by construction: it is decremented only when v[DEPTH-1]=1 and incremented only when a stage is freed or was empty.
- full is combinational from fill_cnt.

## Timing
- Reset (asynchronous assert, synchronous to sys_clk on release): all s=0, v=0, fill_cnt=0, full=0, tap_out=0, tap_vld=0. Hence dout=0 and dout_vld=0.
- Reset asserted mid-shift clears all state immediately, without waiting for a clock edge. The first edge after release behaves as a normal edge.
- Latency din -> dout: exactly DEPTH enabled shift edges. Disabled cycles stretch the latency but never drop or duplicate data.
- Latency stage -> tap_out: 1 cycle. A word present in s[k] at edge n appears on tap_out after edge n+1 when tap_sel=k.
- tap_sel change takes effect on the next edge; there is no extra pipeline.
- Mode and en are sampled on the same edge as din. Mode changes take effect with no idle cycle (e.g. load immediately followed by shift is legal).
- Shift with full=1 and din_vld=1: the oldest word is discarded, fill_cnt stays at DEPTH, and full stays 1.

## Test plan
- Reset: drive random inputs with sys_rst=1, then release -> all outputs 0. Assert sys_rst between clock edges mid-stream -> outputs go to 0 before the next edge.
- Delay line, WIDTH=8, DEPTH=4, en=1, mode=00, din=0x01,0x02,0x03,... with din_vld=1 -> dout=0x01 with dout_vld=1 on the 4th edge. fill_cnt reads 1,2,3,4, then stays 4; full rises on the 4th edge.
- Enable gaps: same stream with en toggling 1,0,1,0 -> dout sequence is 0x01,0x02,... with no gaps or duplicates. Each word takes 4 enabled edges to arrive; held values stay stable while en=0.
- Parallel load then rotate, DEPTH=4: load_data={0xDD,0xCC,0xBB,0xAA} -> s[0..3]=0xAA..0xDD, fill_cnt=4. Then 4 rotate edges -> dout sequence 0xCC,0xBB,0xAA,0xDD, and the stage contents equal the loaded image again.
- Tap and valid, DEPTH=16: shift in 0x10..0x1F with din_vld alternating 1,0. tap_sel=5 -> tap_out equals s[5] one cycle later, and tap_vld matches the alternating pattern. fill_cnt=8 after 16 shifts.
- Clear and non-power-of-2: DEPTH=6, set tap_sel=7 -> tap_out=0 and tap_vld=0. mode=11 on a full register -> fill_cnt=0, full=0 and dout=0 on the next edge. A subsequent shift of din=0x5A, din_vld=1 -> fill_cnt=1.

Source files
------------

// File: rtl/shift_reg_param.sv
// shift_reg_param: DEPTH x WIDTH word shift register with shift, rotate,
// parallel load and clear, per-stage valid flags, fill count and a tap.
module shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_vld,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  input  logic [AW-1:0]          tap_sel,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_vld,
  output logic [WIDTH-1:0]       tap_out,
  output logic                   tap_vld,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full
);

  localparam logic [1:0] M_SHIFT = 2'b00;
  localparam logic [1:0] M_ROT   = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b10;
  localparam logic [1:0] M_CLR   = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] tap_q;
  logic [WIDTH-1:0] tap_d;
  logic             tap_vld_q;
  logic             tap_vld_d;

  always_comb begin
    s_d   = s_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    if (en) begin
      unique case (mode)
        M_SHIFT: begin
          s_d[0] = din;
          v_d[0] = din_vld;
          for (int i = 1; i < DEPTH; i++) begin
            s_d[i] = s_q[i-1];
          end
          v_d[DEPTH-1:1] = v_q[DEPTH-2:0];
          // oldest stage drops out as the new word enters
          cnt_d = cnt_q + CW'(din_vld) - CW'(v_q[DEPTH-1]);
        end
        M_ROT: begin
          s_d[0] = s_q[DEPTH-1];
          v_d[0] = v_q[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) begin
            s_d[i] = s_q[i-1];
          end
          v_d[DEPTH-1:1] = v_q[DEPTH-2:0];
        end
        M_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            s_d[i] = load_data[i*WIDTH +: WIDTH];
          end
          v_d   = '1;
          cnt_d = CNT_MAX;
        end
        M_CLR: begin
          for (int i = 0; i < DEPTH; i++) begin
            s_d[i] = '0;
          end
          v_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  // unmatched selects (beyond DEPTH-1) leave the tap at zero
  always_comb begin
    tap_d     = '0;
    tap_vld_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == AW'(i)) begin
        tap_d     = s_q[i];
        tap_vld_d = v_q[i];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= '0;
      end
      v_q       <= '0;
      cnt_q     <= '0;
      tap_q     <= '0;
      tap_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= s_d[i];
      end
      v_q       <= v_d;
      cnt_q     <= cnt_d;
      tap_q     <= tap_d;
      tap_vld_q <= tap_vld_d;
    end
  end

  assign dout     = s_q[DEPTH-1];
  assign dout_vld = v_q[DEPTH-1];
  assign tap_out  = tap_q;
  assign tap_vld  = tap_vld_q;
  assign fill_cnt = cnt_q;
  assign full     = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_param.sv
// Scoreboard bench for shift_reg_param: DEPTH 4, 16 and 6 instances
// share one input stream; each phase queues checks for one instance.
module tb_shift_reg_param;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic         en;
  logic [1:0]   mode;
  logic [7:0]   din;
  logic         din_vld;
  logic [31:0]  ld4;
  logic [127:0] ld16;
  logic [47:0]  ld6;
  logic [1:0]   ts4;
  logic [3:0]   ts16;
  logic [2:0]   ts6;

  logic [7:0] d4_dout, d4_tap, d16_dout, d16_tap, d6_dout, d6_tap;
  logic       d4_dvld, d4_tvld, d4_full;
  logic       d16_dvld, d16_tvld, d16_full;
  logic       d6_dvld, d6_tvld, d6_full;
  logic [2:0] d4_cnt, d6_cnt;
  logic [4:0] d16_cnt;

  shift_reg_param #(.WIDTH(8), .DEPTH(4)) u4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
    .din(din), .din_vld(din_vld), .load_data(ld4), .tap_sel(ts4),
    .dout(d4_dout), .dout_vld(d4_dvld), .tap_out(d4_tap),
    .tap_vld(d4_tvld), .fill_cnt(d4_cnt), .full(d4_full));

  shift_reg_param #(.WIDTH(8), .DEPTH(16)) u16 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
    .din(din), .din_vld(din_vld), .load_data(ld16), .tap_sel(ts16),
    .dout(d16_dout), .dout_vld(d16_dvld), .tap_out(d16_tap),
    .tap_vld(d16_tvld), .fill_cnt(d16_cnt), .full(d16_full));

  shift_reg_param #(.WIDTH(8), .DEPTH(6)) u6 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
    .din(din), .din_vld(din_vld), .load_data(ld6), .tap_sel(ts6),
    .dout(d6_dout), .dout_vld(d6_dvld), .tap_out(d6_tap),
    .tap_vld(d6_tvld), .fill_cnt(d6_cnt), .full(d6_full));

  localparam int S4_DOUT = 0, S4_DVLD = 1, S4_TAP = 2, S4_TVLD = 3;
  localparam int S4_CNT = 4, S4_FULL = 5, S16_DOUT = 6, S16_DVLD = 7;
  localparam int S16_TAP = 8, S16_TVLD = 9, S16_CNT = 10;
  localparam int S6_DOUT = 11, S6_DVLD = 12, S6_TAP = 13;
  localparam int S6_TVLD = 14, S6_CNT = 15, S6_FULL = 16;

  typedef struct {
    int          tag;
    int          id;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] sig(input int id);
    case (id)
      S4_DOUT:  return 32'(d4_dout);
      S4_DVLD:  return 32'(d4_dvld);
      S4_TAP:   return 32'(d4_tap);
      S4_TVLD:  return 32'(d4_tvld);
      S4_CNT:   return 32'(d4_cnt);
      S4_FULL:  return 32'(d4_full);
      S16_DOUT: return 32'(d16_dout);
      S16_DVLD: return 32'(d16_dvld);
      S16_TAP:  return 32'(d16_tap);
      S16_TVLD: return 32'(d16_tvld);
      S16_CNT:  return 32'(d16_cnt);
      S6_DOUT:  return 32'(d6_dout);
      S6_DVLD:  return 32'(d6_dvld);
      S6_TAP:   return 32'(d6_tap);
      S6_TVLD:  return 32'(d6_tvld);
      S6_CNT:   return 32'(d6_cnt);
      S6_FULL:  return 32'(d6_full);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  task automatic exp_push(input int id, input string nm,
                          input logic [31:0] v);
    exp_t e;
    e.tag  = cyc + 1;
    e.id   = id;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic e, input logic [1:0] m,
                       input logic [7:0] d, input logic dv);
    @(negedge sys_clk);
    en      = e;
    mode    = m;
    din     = d;
    din_vld = dv;
  endtask

  // monitor: after each edge, compare every entry due by this edge
  always begin : mon
    exp_t e;
    @(posedge sys_clk);
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      chk(e.name, sig(e.id), e.exp);
    end
  end

  initial begin
    int n;
    int w;
    logic [7:0] rot_exp [4];
    rot_exp[0] = 8'hCC;
    rot_exp[1] = 8'hBB;
    rot_exp[2] = 8'hAA;
    rot_exp[3] = 8'hDD;

    sys_rst = 1'b1;
    en = 1'b0; mode = 2'b00; din = 8'h00; din_vld = 1'b0;
    ld4 = '0; ld16 = '0; ld6 = '0;
    ts4 = '0; ts16 = '0; ts6 = '0;

    // reset with random activity on the inputs
    repeat (3) begin
      @(negedge sys_clk);
      en      = 1'($urandom());
      mode    = 2'($urandom());
      din     = 8'($urandom());
      din_vld = 1'($urandom());
      ld4     = $urandom();
      ld16    = {$urandom(), $urandom(), $urandom(), $urandom()};
      ld6     = 48'({$urandom(), $urandom()});
      ts4     = 2'($urandom());
      ts16    = 4'($urandom());
      ts6     = 3'($urandom());
    end
    #1;
    chk("rst_dout4", sig(S4_DOUT), 0);
    chk("rst_cnt16", sig(S16_CNT), 0);
    chk("rst_tap16", sig(S16_TAP), 0);

    @(negedge sys_clk);
    sys_rst = 1'b0;
    en = 1'b0; mode = 2'b00; din = 8'h00; din_vld = 1'b0;
    ts4 = '0; ts16 = '0; ts6 = '0;
    exp_push(S4_DOUT, "rel_dout4", 0);
    exp_push(S4_DVLD, "rel_dvld4", 0);
    exp_push(S4_CNT, "rel_cnt4", 0);
    exp_push(S4_FULL, "rel_full4", 0);
    exp_push(S16_TAP, "rel_tap16", 0);
    exp_push(S16_TVLD, "rel_tvld16", 0);
    exp_push(S6_TAP, "rel_tap6", 0);

    // delay line, DEPTH 4
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 2'b00, 8'(k), 1'b1);
      exp_push(S4_DOUT, "dl_dout", k >= 4 ? 32'(k - 3) : 32'd0);
      exp_push(S4_DVLD, "dl_dvld", 32'(k >= 4));
      exp_push(S4_CNT, "dl_cnt", 32'(k < 4 ? k : 4));
      exp_push(S4_FULL, "dl_full", 32'(k >= 4));
    end

    // enable gaps; disabled cycles carry a clear that must be ignored
    drive(1'b1, 2'b11, 8'h00, 1'b0);
    exp_push(S4_CNT, "clr_cnt4", 0);
    exp_push(S4_DOUT, "clr_dout4", 0);
    exp_push(S4_FULL, "clr_full4", 0);
    n = 0;
    w = 1;
    for (int j = 0; j < 16; j++) begin
      if (j % 2 == 0) begin
        drive(1'b1, 2'b00, 8'(w), 1'b1);
        w++;
        n++;
      end else begin
        drive(1'b0, 2'b11, 8'hEE, 1'b1);
      end
      exp_push(S4_DOUT, "gap_dout", n >= 4 ? 32'(n - 3) : 32'd0);
      exp_push(S4_DVLD, "gap_dvld", 32'(n >= 4));
      exp_push(S4_CNT, "gap_cnt", 32'(n < 4 ? n : 4));
    end

    // parallel load then rotate
    ld4 = 32'hDDCC_BBAA;
    drive(1'b1, 2'b10, 8'h00, 1'b0);
    exp_push(S4_DOUT, "ld_dout", 32'hDD);
    exp_push(S4_DVLD, "ld_dvld", 1);
    exp_push(S4_CNT, "ld_cnt", 4);
    exp_push(S4_FULL, "ld_full", 1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b01, 8'h11, 1'b0);
      exp_push(S4_DOUT, "rot_dout", 32'(rot_exp[k]));
      exp_push(S4_CNT, "rot_cnt", 4);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      ts4 = 2'(k);
      exp_push(S4_TAP, "rot_img", 32'(8'hAA + 8'(k * 8'h11)));
      exp_push(S4_TVLD, "rot_img_vld", 1);
    end
    drive(1'b1, 2'b00, 8'h77, 1'b0);
    exp_push(S4_DOUT, "lsh_dout", 32'hCC);
    exp_push(S4_CNT, "lsh_cnt", 3);
    exp_push(S4_FULL, "lsh_full", 0);
    drive(1'b1, 2'b00, 8'h66, 1'b1);
    exp_push(S4_DOUT, "lsh2_dout", 32'hBB);
    exp_push(S4_CNT, "lsh2_cnt", 3);

    // tap and valid pattern, DEPTH 16
    drive(1'b1, 2'b11, 8'h00, 1'b0);
    ts16 = 4'd5;
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 2'b00, 8'(8'h10 + k - 1), 1'((k - 1) % 2 == 0));
      exp_push(S16_TAP, "tap16", k >= 7 ? 32'(8'h10 + k - 7) : 32'd0);
      exp_push(S16_TVLD, "tvld16", 32'(k >= 7 && ((k - 7) % 2 == 0)));
      exp_push(S16_CNT, "cnt16", 32'((k + 1) / 2));
    end
    exp_push(S16_DOUT, "dout16", 32'h10);
    exp_push(S16_DVLD, "dvld16", 1);

    // DEPTH 6: out-of-range tap, load, shift while full, clear
    ts6 = 3'd7;
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    exp_push(S6_TAP, "oor_tap6", 0);
    exp_push(S6_TVLD, "oor_tvld6", 0);
    ld6 = 48'h6564_6362_6160;
    drive(1'b1, 2'b10, 8'h00, 1'b0);
    exp_push(S6_CNT, "ld_cnt6", 6);
    exp_push(S6_FULL, "ld_full6", 1);
    exp_push(S6_DOUT, "ld_dout6", 32'h65);
    exp_push(S6_TAP, "ld_tap6", 0);
    drive(1'b1, 2'b00, 8'h5B, 1'b1);
    exp_push(S6_CNT, "fsh_cnt6", 6);
    exp_push(S6_FULL, "fsh_full6", 1);
    exp_push(S6_DOUT, "fsh_dout6", 32'h64);
    exp_push(S6_DVLD, "fsh_dvld6", 1);
    drive(1'b0, 2'b11, 8'h00, 1'b0);
    ts6 = 3'd2;
    exp_push(S6_TAP, "tap6", 32'h61);
    exp_push(S6_TVLD, "tvld6", 1);
    exp_push(S6_CNT, "hold_cnt6", 6);
    drive(1'b1, 2'b11, 8'h00, 1'b0);
    exp_push(S6_CNT, "clr_cnt6", 0);
    exp_push(S6_FULL, "clr_full6", 0);
    exp_push(S6_DOUT, "clr_dout6", 0);
    exp_push(S6_DVLD, "clr_dvld6", 0);
    drive(1'b1, 2'b00, 8'h5A, 1'b1);
    exp_push(S6_CNT, "one_cnt6", 1);
    exp_push(S6_FULL, "one_full6", 0);

    // reset between edges on a loaded register
    drive(1'b1, 2'b10, 8'h00, 1'b0);
    exp_push(S4_CNT, "pre_cnt4", 4);
    exp_push(S4_DOUT, "pre_dout4", 32'hDD);
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("mid_dout4", sig(S4_DOUT), 0);
    chk("mid_dvld4", sig(S4_DVLD), 0);
    chk("mid_cnt4", sig(S4_CNT), 0);
    chk("mid_full4", sig(S4_FULL), 0);
    chk("mid_cnt16", sig(S16_CNT), 0);
    chk("mid_full6", sig(S6_FULL), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    en = 1'b1; mode = 2'b00; din = 8'h42; din_vld = 1'b1;
    exp_push(S4_CNT, "post_cnt4", 1);
    exp_push(S4_DOUT, "post_dout4", 0);
    exp_push(S4_TAP, "post_tap4", 0);
    exp_push(S16_CNT, "post_cnt16", 1);

    drive(1'b0, 2'b00, 8'h00, 1'b0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
